// File: rtl/pps_divider_multi_if.sv
// Configuration, PPS input and status bundle for pps_divider_multi.
// Channel k of every bus sits at slice [k*w +: w].
`timescale 1ns/1ps
interface pps_divider_multi_if #(
  parameter int N_CH       = 4,
  parameter int DATA_WIDTH = 8
);
  logic                           i_pps_raw;
  logic [N_CH-1:0]                i_start;
  logic [N_CH-1:0]                i_stop;
  logic [2*N_CH-1:0]              i_mode;
  logic [N_CH*DATA_WIDTH-1:0]     i_div_number;
  logic [N_CH*DATA_WIDTH-1:0]     i_burst_count;
  logic [N_CH*3*DATA_WIDTH-1:0]   i_phase_us;
  logic [N_CH*DATA_WIDTH-1:0]     i_width_us;
  logic [N_CH-1:0]                i_invert;
  logic [N_CH-1:0]                o_pps_divided;
  logic [N_CH-1:0]                o_busy;
  logic [N_CH-1:0]                o_done;

  modport master (
    output i_pps_raw, i_start, i_stop, i_mode, i_div_number, i_burst_count,
    output i_phase_us, i_width_us, i_invert,
    input  o_pps_divided, o_busy, o_done
  );

  modport slave (
    input  i_pps_raw, i_start, i_stop, i_mode, i_div_number, i_burst_count,
    input  i_phase_us, i_width_us, i_invert,
    output o_pps_divided, o_busy, o_done
  );
endinterface

// File: rtl/pps_divider_multi.sv
// N_CH-channel PPS divider: shared synchroniser and us timebase, per-channel phase/width/divide pulses.
// Output lags the window condition by one cycle; no backpressure, stop takes effect the next cycle.
`timescale 1ns/1ps
module pps_divider_multi #(
  parameter int N_CH        = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int CLKS_PER_US = 10
) (
  input  logic                 i_clk_10,
  input  logic                 i_rst,
  pps_divider_multi_if.slave   bus
);

  localparam int PW  = 3 * DATA_WIDTH;
  localparam int PW1 = PW + 1;
  localparam int DW1 = DATA_WIDTH + 1;
  localparam int CW  = $clog2(CLKS_PER_US);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_RUN, ST_DONE} state_t;

  logic [1:0]    r_sync;
  logic [CW-1:0] r_presc;
  logic [PW-1:0] r_us;
  logic          w_edge;
  logic [CW-1:0] w_presc_now;
  logic [PW-1:0] w_us_now;

  assign w_edge = (r_sync == 2'b01);

  // The edge cycle itself reads as elapsed time zero, so the window test is a pure us compare.
  assign w_presc_now = w_edge ? '0 : r_presc;
  assign w_us_now    = w_edge ? '0 : r_us;

  always_ff @(posedge i_clk_10) begin
    if (i_rst) begin
      r_sync  <= '0;
      r_presc <= '0;
      r_us    <= '0;
    end else begin
      r_sync <= {r_sync[0], bus.i_pps_raw};
      if (w_presc_now == CW'(CLKS_PER_US - 1)) begin
        r_presc <= '0;
        r_us    <= (w_us_now == '1) ? w_us_now : w_us_now + PW'(1);
      end else begin
        r_presc <= w_presc_now + CW'(1);
        r_us    <= w_us_now;
      end
    end
  end

  logic [N_CH-1:0] w_out;
  logic [N_CH-1:0] w_busy;
  logic [N_CH-1:0] w_done;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    state_t                r_state;
    logic [PW-1:0]         r_phase;
    logic [DATA_WIDTH-1:0] r_width;
    logic [DATA_WIDTH-1:0] r_div;
    logic [DATA_WIDTH-1:0] r_burst;
    logic [DATA_WIDTH-1:0] r_edge_cnt;
    logic [DATA_WIDTH-1:0] r_pulse_cnt;
    logic [1:0]            r_mode;
    logic                  r_pend;
    logic                  r_out;
    logic                  r_busy;
    logic                  r_done;

    logic           w_start;
    logic           w_stop;
    logic           w_reach;
    logic           w_last;
    logic           w_last_new;
    logic           w_end_old;
    logic           w_fire;
    logic           w_in_win;
    logic           w_active;
    logic [DW1-1:0] w_div_eff;
    logic [DW1-1:0] w_burst_eff;
    logic [DW1-1:0] w_pulse_new;
    logic [PW1-1:0] w_us_ext;
    logic [PW1-1:0] w_win_lo;
    logic [PW1-1:0] w_win_hi;

    assign w_start     = bus.i_start[k];
    assign w_stop      = bus.i_stop[k];
    assign w_div_eff   = (r_div == '0)   ? DW1'(1) : {1'b0, r_div};
    assign w_burst_eff = (r_burst == '0) ? DW1'(1) : {1'b0, r_burst};
    assign w_pulse_new = (r_state == ST_ARMED) ? DW1'(1) : {1'b0, r_pulse_cnt} + DW1'(1);

    // Edge counter includes the last fire edge, so a fire happens once it already holds D.
    assign w_reach    = ({1'b0, r_edge_cnt} >= w_div_eff);
    assign w_last     = (r_mode == 2'd2) ? ({1'b0, r_pulse_cnt} >= w_burst_eff) : (r_mode != 2'd0);
    assign w_last_new = (r_mode == 2'd2) ? (w_pulse_new >= w_burst_eff) : (r_mode != 2'd0);

    assign w_us_ext  = {1'b0, w_us_now};
    assign w_win_lo  = {1'b0, r_phase};
    assign w_win_hi  = w_win_lo + PW1'(r_width);
    assign w_end_old = r_pend && (w_edge || (w_us_ext >= w_win_hi));
    assign w_in_win  = (w_us_ext >= w_win_lo) && (w_us_ext < w_win_hi);

    assign w_fire = w_edge && !w_stop &&
                    ((r_state == ST_ARMED) ||
                     ((r_state == ST_RUN) && w_reach && !(w_end_old && w_last)));

    // An edge that aborts a pending window forces one idle cycle before the new window.
    assign w_active = !w_stop && w_in_win &&
                      (w_fire ? !((r_state == ST_RUN) && r_pend)
                              : ((r_state == ST_RUN) && r_pend && !w_edge));

    always_ff @(posedge i_clk_10) begin
      if (i_rst) begin
        r_state     <= ST_IDLE;
        r_phase     <= '0;
        r_width     <= '0;
        r_div       <= '0;
        r_burst     <= '0;
        r_mode      <= '0;
        r_edge_cnt  <= '0;
        r_pulse_cnt <= '0;
        r_pend      <= 1'b0;
        r_out       <= 1'b0;
        r_busy      <= 1'b0;
        r_done      <= 1'b0;
      end else begin
        r_out <= w_active ^ bus.i_invert[k];
        if (w_stop) begin
          r_state <= ST_IDLE;
          r_pend  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              if (w_start) begin
                r_phase <= bus.i_phase_us[k*PW +: PW];
                r_width <= bus.i_width_us[k*DATA_WIDTH +: DATA_WIDTH];
                r_div   <= bus.i_div_number[k*DATA_WIDTH +: DATA_WIDTH];
                r_burst <= bus.i_burst_count[k*DATA_WIDTH +: DATA_WIDTH];
                r_mode  <= bus.i_mode[2*k +: 2];
                r_state <= ST_ARMED;
                r_busy  <= 1'b1;
              end
            end
            ST_ARMED, ST_RUN: begin
              if (w_fire) begin
                r_edge_cnt  <= DATA_WIDTH'(1);
                r_pulse_cnt <= w_pulse_new[DATA_WIDTH-1:0];
                if (r_width != '0) begin
                  r_state <= ST_RUN;
                  r_pend  <= 1'b1;
                end else if (w_last_new) begin
                  r_state <= ST_DONE;
                  r_pend  <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end else begin
                  r_state <= ST_RUN;
                  r_pend  <= 1'b0;
                end
              end else if (r_state == ST_RUN) begin
                if (w_end_old && w_last) begin
                  r_state <= ST_DONE;
                  r_pend  <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end else begin
                  if (w_end_old) r_pend <= 1'b0;
                  if (w_edge)    r_edge_cnt <= r_edge_cnt + DATA_WIDTH'(1);
                end
              end
            end
            default: begin
            end
          endcase
        end
      end
    end

    assign w_out[k]  = r_out;
    assign w_busy[k] = r_busy;
    assign w_done[k] = r_done;
  end

  assign bus.o_pps_divided = w_out;
  assign bus.o_busy        = w_busy;
  assign bus.o_done        = w_done;

endmodule
